// File: rtl/gpio_bank_pkg.sv
// Shared register map, reset values and helpers for the GPIO pad bank.
package gpio_bank_pkg;

    localparam logic [3:0] GPIO_ADR_IN      = 4'd0;
    localparam logic [3:0] GPIO_ADR_OUT     = 4'd1;
    localparam logic [3:0] GPIO_ADR_OE      = 4'd2;
    localparam logic [3:0] GPIO_ADR_CS      = 4'd3;
    localparam logic [3:0] GPIO_ADR_SL      = 4'd4;
    localparam logic [3:0] GPIO_ADR_IE      = 4'd5;
    localparam logic [3:0] GPIO_ADR_PU      = 4'd6;
    localparam logic [3:0] GPIO_ADR_PD      = 4'd7;
    localparam logic [3:0] GPIO_ADR_RISE_EN = 4'd8;
    localparam logic [3:0] GPIO_ADR_FALL_EN = 4'd9;
    localparam logic [3:0] GPIO_ADR_STATUS  = 4'd10;
    localparam logic [3:0] GPIO_ADR_OUT_SET = 4'd11;
    localparam logic [3:0] GPIO_ADR_OUT_CLR = 4'd12;

    localparam logic [31:0] GPIO_IE_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] GPIO_SL_RST = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] out;
        logic [31:0] oe;
        logic [31:0] cs;
        logic [31:0] sl;
        logic [31:0] ie;
        logic [31:0] pu;
        logic [31:0] pd;
    } gpio_cfg_t;

    function automatic logic [31:0] pad_mask(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] mask,
                                               input logic [31:0] val);
        return (cur & ~mask) | (val & mask);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage synchroniser bringing asynchronous pad inputs into clk_i.
module gpio_sync #(
    parameter int NUM_PADS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_in,
    input  logic [NUM_PADS-1:0] i_async,
    output logic [NUM_PADS-1:0] o_sync
);

    logic [SYNC_STAGES-1:0][NUM_PADS-1:0] r_chain;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// Wishbone-attached GPIO pad bank: pad configuration registers, input
// synchroniser, per-pad edge interrupts with W1C status and a level irq.
module gpio_bank
    import gpio_bank_pkg::*;
#(
    parameter int NUM_PADS    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_in,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [3:0]          wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    input  logic [NUM_PADS-1:0] pad_in_i,
    output logic [NUM_PADS-1:0] pad_out_o,
    output logic [NUM_PADS-1:0] pad_oe_o,
    output logic [NUM_PADS-1:0] pad_cs_o,
    output logic [NUM_PADS-1:0] pad_sl_o,
    output logic [NUM_PADS-1:0] pad_ie_o,
    output logic [NUM_PADS-1:0] pad_pu_o,
    output logic [NUM_PADS-1:0] pad_pd_o,
    output logic                irq_o
);

    localparam logic [31:0] PAD_MASK = pad_mask(NUM_PADS);
    localparam gpio_cfg_t   CFG_RST  = '{
        out: '0, oe: '0, cs: '0,
        sl: GPIO_SL_RST & PAD_MASK,
        ie: GPIO_IE_RST & PAD_MASK,
        pu: '0, pd: '0
    };

    gpio_cfg_t           r_cfg;
    logic [31:0]         r_rise_en;
    logic [31:0]         r_fall_en;
    logic [31:0]         r_status;
    logic [NUM_PADS-1:0] r_prev;
    logic                r_ack;
    logic [31:0]         r_dat;
    logic                r_irq;

    logic [NUM_PADS-1:0] w_sync;
    logic                w_req;
    logic                w_wr;
    logic                w_rd;
    logic [31:0]         w_bmask;
    logic [31:0]         w_wdat;
    logic [31:0]         w_sync32;
    logic [31:0]         w_prev32;
    logic [31:0]         w_in;
    logic [31:0]         w_rise;
    logic [31:0]         w_fall;
    logic [31:0]         w_clr;
    logic [31:0]         w_rdata;
    gpio_cfg_t           w_cfg_nxt;
    logic [31:0]         w_rise_en_nxt;
    logic [31:0]         w_fall_en_nxt;

    gpio_sync #(
        .NUM_PADS   (NUM_PADS),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .i_async(pad_in_i),
        .o_sync (w_sync)
    );

    // A request is accepted only while ack is low, so each access takes two cycles.
    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr     = w_req & wb_we_i;
    assign w_rd     = w_req & ~wb_we_i;
    assign w_bmask  = sel_mask(wb_sel_i) & PAD_MASK;
    assign w_wdat   = wb_dat_i & w_bmask;

    assign w_sync32 = 32'(w_sync);
    assign w_prev32 = 32'(r_prev);
    assign w_in     = w_sync32 & r_cfg.ie;
    assign w_rise   = w_sync32 & ~w_prev32 & r_rise_en & r_cfg.ie;
    assign w_fall   = ~w_sync32 & w_prev32 & r_fall_en & r_cfg.ie;

    always_comb begin
        w_cfg_nxt     = r_cfg;
        w_rise_en_nxt = r_rise_en;
        w_fall_en_nxt = r_fall_en;
        w_clr         = '0;
        if (w_wr) begin
            case (wb_adr_i)
                GPIO_ADR_OUT:     w_cfg_nxt.out = byte_merge(r_cfg.out, w_bmask, wb_dat_i);
                GPIO_ADR_OE:      w_cfg_nxt.oe  = byte_merge(r_cfg.oe,  w_bmask, wb_dat_i);
                GPIO_ADR_CS:      w_cfg_nxt.cs  = byte_merge(r_cfg.cs,  w_bmask, wb_dat_i);
                GPIO_ADR_SL:      w_cfg_nxt.sl  = byte_merge(r_cfg.sl,  w_bmask, wb_dat_i);
                GPIO_ADR_IE:      w_cfg_nxt.ie  = byte_merge(r_cfg.ie,  w_bmask, wb_dat_i);
                GPIO_ADR_PU:      w_cfg_nxt.pu  = byte_merge(r_cfg.pu,  w_bmask, wb_dat_i);
                GPIO_ADR_PD:      w_cfg_nxt.pd  = byte_merge(r_cfg.pd,  w_bmask, wb_dat_i);
                GPIO_ADR_RISE_EN: w_rise_en_nxt = byte_merge(r_rise_en, w_bmask, wb_dat_i);
                GPIO_ADR_FALL_EN: w_fall_en_nxt = byte_merge(r_fall_en, w_bmask, wb_dat_i);
                GPIO_ADR_STATUS:  w_clr         = w_wdat;
                GPIO_ADR_OUT_SET: w_cfg_nxt.out = r_cfg.out | w_wdat;
                GPIO_ADR_OUT_CLR: w_cfg_nxt.out = r_cfg.out & ~w_wdat;
                default:          w_clr         = '0;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (wb_adr_i)
            GPIO_ADR_IN:      w_rdata = w_in;
            GPIO_ADR_OUT:     w_rdata = r_cfg.out;
            GPIO_ADR_OE:      w_rdata = r_cfg.oe;
            GPIO_ADR_CS:      w_rdata = r_cfg.cs;
            GPIO_ADR_SL:      w_rdata = r_cfg.sl;
            GPIO_ADR_IE:      w_rdata = r_cfg.ie;
            GPIO_ADR_PU:      w_rdata = r_cfg.pu;
            GPIO_ADR_PD:      w_rdata = r_cfg.pd;
            GPIO_ADR_RISE_EN: w_rdata = r_rise_en;
            GPIO_ADR_FALL_EN: w_rdata = r_fall_en;
            GPIO_ADR_STATUS:  w_rdata = r_status;
            default:          w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_cfg     <= CFG_RST;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_status  <= '0;
            r_prev    <= '0;
            r_ack     <= 1'b0;
            r_dat     <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_cfg     <= w_cfg_nxt;
            r_rise_en <= w_rise_en_nxt;
            r_fall_en <= w_fall_en_nxt;
            // New edge events override a same-cycle W1C of the same bit.
            r_status  <= (r_status & ~w_clr) | w_rise | w_fall;
            r_prev    <= w_sync;
            r_ack     <= w_req;
            r_dat     <= w_rd ? w_rdata : '0;
            r_irq     <= |r_status;
        end
    end

    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_dat;
    assign irq_o     = r_irq;
    assign pad_out_o = r_cfg.out[NUM_PADS-1:0];
    assign pad_oe_o  = r_cfg.oe[NUM_PADS-1:0];
    assign pad_cs_o  = r_cfg.cs[NUM_PADS-1:0];
    assign pad_sl_o  = r_cfg.sl[NUM_PADS-1:0];
    assign pad_ie_o  = r_cfg.ie[NUM_PADS-1:0];
    assign pad_pu_o  = r_cfg.pu[NUM_PADS-1:0];
    assign pad_pd_o  = r_cfg.pd[NUM_PADS-1:0];

endmodule

// File: tb/tb_gpio_bank.sv
// Bench for gpio_bank: address-indexed register model checked every cycle,
// plus directed bus sequences with hand-computed expectations.
module tb_gpio_bank;

    localparam int          NP = 4;
    localparam int          SS = 2;
    localparam logic [31:0] PM = 32'h0000_000F;

    logic          clk_i = 1'b0;
    logic          rst_in;
    logic          cyc, stb, we;
    logic [3:0]    adr;
    logic [31:0]   dat_i;
    logic [3:0]    sel;
    logic [31:0]   dat_o;
    logic          ack;
    logic [NP-1:0] pad_in;
    logic [NP-1:0] pad_out, pad_oe, pad_cs, pad_sl, pad_ie, pad_pu, pad_pd;
    logic          irq;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    gpio_bank #(.NUM_PADS(NP), .SYNC_STAGES(SS)) dut (
        .clk_i    (clk_i),
        .rst_in   (rst_in),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_dat_i (dat_i),
        .wb_sel_i (sel),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack),
        .pad_in_i (pad_in),
        .pad_out_o(pad_out),
        .pad_oe_o (pad_oe),
        .pad_cs_o (pad_cs),
        .pad_sl_o (pad_sl),
        .pad_ie_o (pad_ie),
        .pad_pu_o (pad_pu),
        .pad_pd_o (pad_pd),
        .irq_o    (irq)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers held by bus address (1..9 config, 10 status); the
    // synchronised input is the pad value seen SS edges ago, prev one edge older.
    logic [31:0]   m_reg [16];
    logic [NP-1:0] m_hist [SS+1];
    logic          m_ack, m_irq;
    logic [31:0]   m_dat;

    initial begin : model
        logic [31:0] sync_v, prev_v, ev, bm, wd, rd;
        logic [31:0] nr [16];
        logic        req;
        forever begin
            @(posedge clk_i);
            if (!rst_in) begin
                for (int a = 0; a < 16; a++) m_reg[a] = '0;
                m_reg[4] = PM;
                m_reg[5] = PM;
                for (int k = 0; k <= SS; k++) m_hist[k] = '0;
                m_ack = 1'b0;
                m_irq = 1'b0;
                m_dat = '0;
            end else begin
                sync_v = 32'(m_hist[SS-1]);
                prev_v = 32'(m_hist[SS]);
                ev = ((sync_v & ~prev_v & m_reg[8]) | (~sync_v & prev_v & m_reg[9])) & m_reg[5] & PM;
                req = cyc & stb & ~m_ack;
                bm = '0;
                for (int b = 0; b < 4; b++) if (sel[b]) bm[8*b +: 8] = 8'hFF;
                bm = bm & PM;
                wd = dat_i & bm;
                rd = '0;
                if (req && !we) begin
                    if (adr == 4'd0) rd = sync_v & m_reg[5];
                    else if (adr <= 4'd10) rd = m_reg[adr];
                end
                for (int a = 0; a < 16; a++) nr[a] = m_reg[a];
                nr[10] = m_reg[10] | ev;
                if (req && we) begin
                    if (adr >= 4'd1 && adr <= 4'd9) nr[adr] = (m_reg[adr] & ~bm) | wd;
                    else if (adr == 4'd10) nr[10] = (m_reg[10] & ~wd) | ev;
                    else if (adr == 4'd11) nr[1] = m_reg[1] | wd;
                    else if (adr == 4'd12) nr[1] = m_reg[1] & ~wd;
                end
                m_irq = |m_reg[10];
                m_ack = req;
                m_dat = rd;
                for (int a = 0; a < 16; a++) m_reg[a] = nr[a];
                for (int k = SS; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = pad_in;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk_i);
            if (cmp_en) begin
                check("pad_out", 32'(pad_out), m_reg[1]);
                check("pad_oe",  32'(pad_oe),  m_reg[2]);
                check("pad_cs",  32'(pad_cs),  m_reg[3]);
                check("pad_sl",  32'(pad_sl),  m_reg[4]);
                check("pad_ie",  32'(pad_ie),  m_reg[5]);
                check("pad_pu",  32'(pad_pu),  m_reg[6]);
                check("pad_pd",  32'(pad_pd),  m_reg[7]);
                check("irq",     32'(irq),     32'(m_irq));
                check("ack",     32'(ack),     32'(m_ack));
                if (m_ack) check("rdata", dat_o, m_dat);
            end
        end
    end

    // Called at a negedge; returns at the negedge on which ack is seen.
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r, output int lat);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        lat = 0;
        do begin
            @(negedge clk_i);
            lat++;
        end while (!ack && lat < 8);
        if (!ack) begin
            total++;
            bad++;
            $display("FAIL bus_timeout: adr %0d no ack after %0d cycles", a, lat);
        end
        r = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
        logic [31:0] r;
        int lat;
        bus(1'b1, a, d, s, r, lat);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int lat;
        bus(1'b0, a, 32'h0, 4'hF, r, lat);
        check(name, r, exp);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] r;
        int lat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
        pad_in = '0;
        rst_in = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_in = 1'b1;
        cmp_en = 1'b1;

        // reset state and handshake
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_pad_ie", 32'(pad_ie), 32'hF);
        bus(1'b0, 4'd5, 32'h0, 4'hF, r, lat);
        check("ack_latency", 32'(lat), 32'd1);
        check("rd_ie_rst", r, 32'hF);
        @(negedge clk_i);
        check("ack_one_cycle", 32'(ack), 32'h0);
        rd_chk("rd_sl_rst", 4'd4, 32'hF);
        rd_chk("rd_oe_rst", 4'd2, 32'h0);
        rd_chk("rd_status_rst", 4'd10, 32'h0);

        // OUT write, set, clear
        wr(4'd1, 32'h5);
        check("out_wr", 32'(pad_out), 32'h5);
        wr(4'd11, 32'h2);
        check("out_set", 32'(pad_out), 32'h7);
        wr(4'd12, 32'h4);
        check("out_clr", 32'(pad_out), 32'h3);
        rd_chk("rd_out", 4'd1, 32'h3);

        // rising edge on pad 0: status after SS+1 edges, irq one edge later
        wr(4'd8, 32'h1);
        pad_in = 4'b0001;
        repeat (SS + 1) @(negedge clk_i);
        check("irq_not_yet", 32'(irq), 32'h0);
        @(negedge clk_i);
        check("irq_rise", 32'(irq), 32'h1);
        rd_chk("rd_status_rise", 4'd10, 32'h1);
        wr(4'd10, 32'h1);
        check("irq_lags_clear", 32'(irq), 32'h1);
        @(negedge clk_i);
        check("irq_cleared", 32'(irq), 32'h0);
        rd_chk("rd_status_w1c", 4'd10, 32'h0);

        // falling edge on pad 1 masked by IE, then unmasked
        wr(4'd9, 32'h2);
        wr(4'd5, 32'hD);
        pad_in = 4'b0011;
        repeat (4) @(negedge clk_i);
        rd_chk("rd_in_masked", 4'd0, 32'h1);
        pad_in = 4'b0001;
        repeat (4) @(negedge clk_i);
        rd_chk("rd_status_masked", 4'd10, 32'h0);
        wr(4'd5, 32'hF);
        pad_in = 4'b0011;
        repeat (4) @(negedge clk_i);
        rd_chk("rd_in_all", 4'd0, 32'h3);
        rd_chk("rd_status_rise_off", 4'd10, 32'h0);
        pad_in = 4'b0001;
        repeat (4) @(negedge clk_i);
        rd_chk("rd_status_fall", 4'd10, 32'h2);
        wr(4'd10, 32'h2);

        // W1C colliding with a new rising edge on pad 0: set wins
        pad_in = 4'b0000;
        repeat (4) @(negedge clk_i);
        rd_chk("rd_status_pre", 4'd10, 32'h0);
        pad_in = 4'b0001;
        repeat (SS) @(negedge clk_i);
        wr(4'd10, 32'h1);
        rd_chk("rd_status_set_wins", 4'd10, 32'h1);
        wr(4'd10, 32'h1);
        rd_chk("rd_status_cleared", 4'd10, 32'h0);

        // byte lanes, pad masking, unmapped and read-only addresses
        wr(4'd6, 32'hFFFF_FFFF, 4'b0001);
        rd_chk("rd_pu_lane0", 4'd6, 32'hF);
        wr(4'd2, 32'h0000_FFFF, 4'b0010);
        rd_chk("rd_oe_lane1", 4'd2, 32'h0);
        wr(4'd3, 32'h0000_00A5, 4'b0001);
        rd_chk("rd_cs", 4'd3, 32'h5);
        wr(4'd0, 32'hF);
        wr(4'd14, 32'hF);
        rd_chk("rd_in_ro", 4'd0, 32'h1);
        rd_chk("rd_unmapped", 4'd14, 32'h0);
        rd_chk("rd_out_set_wo", 4'd11, 32'h0);

        // reset asserted together with a request: no ack, registers restored
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd6; sel = 4'hF;
        rst_in = 1'b0;
        @(negedge clk_i);
        check("rst_mid_ack", 32'(ack), 32'h0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk_i);
        rst_in = 1'b1;
        check("rst_pad_out", 32'(pad_out), 32'h0);
        rd_chk("rd_pu_after_rst", 4'd6, 32'h0);
        rd_chk("rd_ie_after_rst", 4'd5, 32'hF);
        rd_chk("rd_sl_after_rst", 4'd4, 32'hF);
        rd_chk("rd_rise_after_rst", 4'd8, 32'h0);
        rd_chk("rd_cs_after_rst", 4'd3, 32'h0);

        repeat (2) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
